// File: rtl/stick_conditioner_pkg.sv
// Shared stick codes and helpers for the tail-light front end.
// The sequencer imports the same codes.
package stick_conditioner_pkg;

    localparam logic [1:0] STICK_NONE  = 2'd0;
    localparam logic [1:0] STICK_RIGHT = 2'd1;
    localparam logic [1:0] STICK_LEFT  = 2'd2;

    typedef logic [1:0] stick_t;

    // Counter width for a 0..n-1 counter, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Both pressed is a hazard and resolves to neutral.
    function automatic stick_t resolve_stick(
        input logic l,
        input logic r
    );
        stick_t s;
        unique case (1'b1)
            (l && !r): s = STICK_LEFT;
            (r && !l): s = STICK_RIGHT;
            default:   s = STICK_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stick_conditioner_debouncer.sv
// Two-flop synchroniser followed by a stable-run debouncer.
// state flips only after DEBOUNCE_CYCLES differing synced samples.
module switch_debouncer
    import stick_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
)(
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic state
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [1:0]    sync_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          state_q;
    logic          state_d;
    logic          synced;

    assign synced = sync_q[1];
    assign state  = state_q;

    // Sync chain, run counter and accepted state; any bounce clears the run.
    always_comb begin
        sync_d  = {sync_q[0], raw};
        cnt_d   = '0;
        state_d = state_q;
        if (synced != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Registers; reset abandons any count in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/stick_conditioner.sv
// Front end for the tail-light sequencer: debounced switches,
// resolved stick code and a slow step enable.
module stick_conditioner
    import stick_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 8
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_left,
    input  logic       raw_right,
    output logic [1:0] stick,
    output logic       step,
    output logic       conflict
);

    localparam int TW = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic          l_state;
    logic          r_state;
    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;
    logic          wrap;
    stick_t        resolved;
    stick_t        stick_q;
    stick_t        stick_d;
    logic          step_q;
    logic          step_d;
    logic          conflict_q;
    logic          conflict_d;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_left),
        .state(l_state)
    );

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_right),
        .state(r_state)
    );

    assign wrap     = (tick_q == TICK_LAST);
    assign resolved = resolve_stick(l_state, r_state);

    // Tick phase, step pulse, stick load on wrap, conflict every cycle.
    always_comb begin
        tick_d     = wrap ? '0 : tick_q + TW'(1);
        step_d     = wrap;
        stick_d    = wrap ? resolved : stick_q;
        conflict_d = l_state & r_state;
    end

    // Output and tick registers; reset restarts the tick phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q     <= '0;
            step_q     <= 1'b0;
            stick_q    <= STICK_NONE;
            conflict_q <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            step_q     <= step_d;
            stick_q    <= stick_d;
            conflict_q <= conflict_d;
        end
    end

    assign stick    = stick_q;
    assign step     = step_q;
    assign conflict = conflict_q;

endmodule
